mem_port_arbiter: RTL and testbench

//  Shares one downstream memory port between the core's instruction-fetch (imem) and data (dmem) requesters.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 24 ++
 rtl/mem_arb_req_buf.sv | 27 ++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the imem/dmem memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_WIDTH  = 64;
  localparam int unsigned FETCH_WIDTH = 64;
  localparam int unsigned SIZE_W      = $clog2(FETCH_WIDTH / 8);

  typedef enum logic {
    REQ_IMEM = 1'b0,
    REQ_DMEM = 1'b1
  } requester_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                   is_write;
    logic [DATA_WIDTH-1:0]  addr;
    logic [SIZE_W-1:0]      size;
    logic [FETCH_WIDTH-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-style memory port: busy / rd_en / wr_en / rdy plus address and data.
// The master drives requests; the slave answers with busy, rdy and read data.
interface mem_port_arbiter_if;

  logic                                rd_en;
  logic                                wr_en;
  logic [mem_arb_pkg::DATA_WIDTH-1:0]  addr;
  logic [mem_arb_pkg::SIZE_W-1:0]      wr_size;
  logic [mem_arb_pkg::FETCH_WIDTH-1:0] wr_data;
  logic                                busy;
  logic                                rdy;
  logic [mem_arb_pkg::FETCH_WIDTH-1:0] rd_data;

  modport master (
    output rd_en, wr_en, addr, wr_size, wr_data,
    input  busy, rdy, rd_data
  );

  modport slave (
    input  rd_en, wr_en, addr, wr_size, wr_data,
    output busy, rdy, rd_data
  );

endinterface

// File: rtl/mem_arb_req_buf.sv
// One-entry request buffer: load captures a request, clear retires it.
module mem_arb_req_buf
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     clear,
  input  mem_req_t req_in,
  output logic     valid,
  output mem_req_t req
);

  // Hold the request until it is issued downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      req   <= req_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between the fetch (imem) and data (dmem)
// requesters, with one buffered request each and one transaction in flight.
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise
// dmem has fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  imem,
  mem_port_arbiter_if.slave  dmem,
  mem_port_arbiter_if.master mem
);

  arb_state_e state, state_nxt;
  requester_e owner, winner;
  logic       imem_valid, dmem_valid;
  logic       imem_accept, dmem_accept, fire;
  mem_req_t   imem_in, dmem_in, imem_req, dmem_req, win_req;
  logic       unused_imem;

  // The fetch side never writes
  assign unused_imem = ^{imem.wr_en, imem.wr_size, imem.wr_data};

  assign imem.busy = imem_valid | ((state == WAIT) & (owner == REQ_IMEM));
  assign dmem.busy = dmem_valid | ((state == WAIT) & (owner == REQ_DMEM));

  assign imem_accept = imem.rd_en & ~imem.busy;
  assign dmem_accept = (dmem.rd_en | dmem.wr_en) & ~dmem.busy;

  assign imem_in = '{is_write: 1'b0, addr: imem.addr, size: '0, data: '0};
  assign dmem_in = '{is_write: dmem.wr_en, addr: dmem.addr,
                     size: dmem.wr_size, data: dmem.wr_data};

  assign fire    = (state == IDLE) & (imem_valid | dmem_valid) & ~mem.busy;
  assign win_req = (winner == REQ_DMEM) ? dmem_req : imem_req;

  mem_arb_req_buf u_imem_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (imem_accept),
    .clear  (fire & (winner == REQ_IMEM)),
    .req_in (imem_in),
    .valid  (imem_valid),
    .req    (imem_req)
  );

  mem_arb_req_buf u_dmem_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (dmem_accept),
    .clear  (fire & (winner == REQ_DMEM)),
    .req_in (dmem_in),
    .valid  (dmem_valid),
    .req    (dmem_req)
  );

`ifdef MEM_ARB_RR_EN
  requester_e rr_last;

  // Remember who was granted last; starts as dmem so imem wins the first tie
  always_ff @(posedge clk) begin
    if (rst)       rr_last <= REQ_DMEM;
    else if (fire) rr_last <= winner;
  end
`endif

  // Pick the buffer to issue from
  always_comb begin
    winner = REQ_IMEM;
    if (imem_valid && dmem_valid) begin
`ifdef MEM_ARB_RR_EN
      winner = (rr_last == REQ_DMEM) ? REQ_IMEM : REQ_DMEM;
`else
      winner = REQ_DMEM;
`endif
    end else if (dmem_valid) begin
      winner = REQ_DMEM;
    end
  end

  // State and owner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= REQ_IMEM;
    end else begin
      state <= state_nxt;
      if (fire) owner <= winner;
    end
  end

  // Next state: issue moves to WAIT, downstream completion returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire)     state_nxt = WAIT;
      WAIT:    if (mem.rdy)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Issue strobes and completion forwarding, both combinational
  always_comb begin
    mem.rd_en    = 1'b0;
    mem.wr_en    = 1'b0;
    mem.addr     = '0;
    mem.wr_size  = '0;
    mem.wr_data  = '0;
    imem.rdy     = 1'b0;
    dmem.rdy     = 1'b0;
    imem.rd_data = '0;
    dmem.rd_data = '0;
    if (fire) begin
      mem.rd_en   = ~win_req.is_write;
      mem.wr_en   = win_req.is_write;
      mem.addr    = win_req.addr;
      mem.wr_size = win_req.size;
      mem.wr_data = win_req.data;
    end
    if ((state == WAIT) && mem.rdy) begin
      if (owner == REQ_IMEM) begin
        imem.rdy     = 1'b1;
        imem.rd_data = mem.rd_data;
      end else begin
        dmem.rdy     = 1'b1;
        dmem.rd_data = mem.rd_data;
      end
    end
  end

`ifndef SYNTHESIS
  logic late_rdy_ok;

  // Protocol checks; a completion orphaned by reset may legitimately arrive later
  always_ff @(posedge clk) begin
    if (rst)                             late_rdy_ok <= late_rdy_ok | (state == WAIT);
    else if (fire)                       late_rdy_ok <= 1'b0;
    else if ((state == IDLE) && mem.rdy) late_rdy_ok <= 1'b0;
    if (!rst && (state == IDLE) && mem.rdy && !late_rdy_ok)
      $error("mem_port_arbiter: spurious mem rdy while idle");
    if (!rst && dmem_accept && dmem.rd_en && dmem.wr_en)
      $fatal(1, "mem_port_arbiter: dmem read and write asserted together");
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_port_arbiter_if imem_if ();
  mem_port_arbiter_if dmem_if ();
  mem_port_arbiter_if mem_if ();

  mem_port_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .imem (imem_if),
    .dmem (dmem_if),
    .mem  (mem_if)
  );

  always #5 clk = ~clk;

`ifdef MEM_ARB_RR_EN
  localparam logic [63:0] FIRST_ADDR  = 64'h0;
  localparam logic [63:0] SECOND_ADDR = 64'h2000;
  localparam bit          FIRST_DMEM  = 1'b0;
`else
  localparam logic [63:0] FIRST_ADDR  = 64'h2000;
  localparam logic [63:0] SECOND_ADDR = 64'h0;
  localparam bit          FIRST_DMEM  = 1'b1;
`endif

  task automatic idle_in();
    imem_if.rd_en = 1'b0; imem_if.wr_en = 1'b0; imem_if.addr = '0;
    imem_if.wr_size = '0; imem_if.wr_data = '0;
    dmem_if.rd_en = 1'b0; dmem_if.wr_en = 1'b0; dmem_if.addr = '0;
    dmem_if.wr_size = '0; dmem_if.wr_data = '0;
    mem_if.busy = 1'b0; mem_if.rdy = 1'b0; mem_if.rd_data = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({imem_if.busy, dmem_if.busy, imem_if.rdy, dmem_if.rdy, mem_if.rd_en, mem_if.wr_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/rdy/en=%b required 000000",
               {imem_if.busy, dmem_if.busy, imem_if.rdy, dmem_if.rdy, mem_if.rd_en, mem_if.wr_en});
    end
    n_tests++;
    if (mem_if.addr !== 64'h0 || mem_if.wr_data !== 64'h0 || mem_if.wr_size !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h data=%h required 0", mem_if.addr, mem_if.wr_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_if.busy !== 1'b0 || dmem_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: imem=%b dmem=%b required 0 0", imem_if.busy, dmem_if.busy);
    end
  endtask

  task automatic test_lone_fetch();
    @(posedge clk); #1;
    imem_if.rd_en = 1'b1; imem_if.addr = 64'h100;
    @(posedge clk); #1 imem_if.rd_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_if.rd_en !== 1'b1 || mem_if.wr_en !== 1'b0 || mem_if.addr !== 64'h100) begin
      n_fail++;
      $display("FAIL fetch_issue: rd=%b wr=%b addr=%h required 1 0 100", mem_if.rd_en, mem_if.wr_en, mem_if.addr);
    end
    n_tests++;
    if (imem_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_busy: got %b required 1", imem_if.busy);
    end
    @(posedge clk); #1;
    mem_if.rdy = 1'b1; mem_if.rd_data = 64'hDEADBEEF00000013;
    @(negedge clk);
    n_tests++;
    if (imem_if.rdy !== 1'b1 || dmem_if.rdy !== 1'b0 || imem_if.rd_data !== 64'hDEADBEEF00000013) begin
      n_fail++;
      $display("FAIL fetch_rdy: irdy=%b drdy=%b data=%h required 1 0 deadbeef00000013",
               imem_if.rdy, dmem_if.rdy, imem_if.rd_data);
    end
    @(posedge clk); #1 mem_if.rdy = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_if.busy !== 1'b0 || imem_if.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_done: busy=%b rdy=%b required 0 0", imem_if.busy, imem_if.rdy);
    end
  endtask

  task automatic test_priority();
    do_reset();
    @(posedge clk); #1;
    imem_if.rd_en = 1'b1; imem_if.addr = 64'h0;
    dmem_if.rd_en = 1'b1; dmem_if.addr = 64'h2000;
    @(posedge clk); #1;
    imem_if.rd_en = 1'b0; dmem_if.rd_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_if.rd_en !== 1'b1 || mem_if.addr !== FIRST_ADDR) begin
      n_fail++;
      $display("FAIL prio_first: rd=%b addr=%h required 1 %h", mem_if.rd_en, mem_if.addr, FIRST_ADDR);
    end
    @(posedge clk); #1;
    mem_if.rdy = 1'b1; mem_if.rd_data = 64'hA1;
    @(negedge clk);
    n_tests++;
    if (dmem_if.rdy !== FIRST_DMEM || imem_if.rdy !== !FIRST_DMEM || mem_if.rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_first_rdy: drdy=%b irdy=%b rd=%b required %b %b 0",
               dmem_if.rdy, imem_if.rdy, mem_if.rd_en, FIRST_DMEM, !FIRST_DMEM);
    end
    @(posedge clk); #1 mem_if.rdy = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_if.rd_en !== 1'b1 || mem_if.addr !== SECOND_ADDR) begin
      n_fail++;
      $display("FAIL prio_second: rd=%b addr=%h required 1 %h", mem_if.rd_en, mem_if.addr, SECOND_ADDR);
    end
    @(posedge clk); #1;
    mem_if.rdy = 1'b1; mem_if.rd_data = 64'hB2;
    @(negedge clk);
    n_tests++;
    if (dmem_if.rdy !== !FIRST_DMEM || imem_if.rdy !== FIRST_DMEM) begin
      n_fail++;
      $display("FAIL prio_second_rdy: drdy=%b irdy=%b required %b %b",
               dmem_if.rdy, imem_if.rdy, !FIRST_DMEM, FIRST_DMEM);
    end
    @(posedge clk); #1 mem_if.rdy = 1'b0;
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    dmem_if.wr_en = 1'b1; dmem_if.addr = 64'h40;
    dmem_if.wr_size = SIZE_W'(3); dmem_if.wr_data = 64'h1122334455667788;
    @(posedge clk); #1 dmem_if.wr_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_if.wr_en !== 1'b1 || mem_if.rd_en !== 1'b0 || mem_if.addr !== 64'h40 ||
        mem_if.wr_size !== SIZE_W'(3) || mem_if.wr_data !== 64'h1122334455667788) begin
      n_fail++;
      $display("FAIL write_issue: wr=%b rd=%b addr=%h size=%0d data=%h required 1 0 40 3 1122334455667788",
               mem_if.wr_en, mem_if.rd_en, mem_if.addr, mem_if.wr_size, mem_if.wr_data);
    end
    @(posedge clk); #1 mem_if.rdy = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dmem_if.rdy !== 1'b1 || imem_if.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_rdy: drdy=%b irdy=%b required 1 0", dmem_if.rdy, imem_if.rdy);
    end
    @(posedge clk); #1 mem_if.rdy = 1'b0;
  endtask

  task automatic test_mem_busy();
    @(posedge clk); #1;
    mem_if.busy = 1'b1; imem_if.rd_en = 1'b1; imem_if.addr = 64'h500;
    @(posedge clk); #1 imem_if.rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (mem_if.rd_en !== 1'b0 || imem_if.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_hold[%0d]: rd=%b busy=%b required 0 1", i, mem_if.rd_en, imem_if.busy);
      end
      @(posedge clk); #1;
    end
    mem_if.busy = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_if.rd_en !== 1'b1 || mem_if.addr !== 64'h500) begin
      n_fail++;
      $display("FAIL busy_release: rd=%b addr=%h required 1 500", mem_if.rd_en, mem_if.addr);
    end
    @(posedge clk); #1 mem_if.rdy = 1'b1;
    @(negedge clk);
    n_tests++;
    if (imem_if.rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rdy: got %b required 1", imem_if.rdy);
    end
    @(posedge clk); #1 mem_if.rdy = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    imem_if.rd_en = 1'b1; imem_if.addr = 64'h600;
    @(posedge clk); #1 imem_if.rd_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_if.rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwait_issue: rd=%b required 1", mem_if.rd_en);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_if.busy !== 1'b0 || dmem_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait_busy: imem=%b dmem=%b required 0 0", imem_if.busy, dmem_if.busy);
    end
    @(posedge clk); #1 mem_if.rdy = 1'b1;
    @(negedge clk);
    n_tests++;
    if (imem_if.rdy !== 1'b0 || dmem_if.rdy !== 1'b0 || mem_if.rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait_late_rdy: irdy=%b drdy=%b rd=%b required 0 0 0",
               imem_if.rdy, dmem_if.rdy, mem_if.rd_en);
    end
    @(posedge clk); #1 mem_if.rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    int  issues = 0, rdys = 0, viol = 0, cycles = 0;
    bit  outst = 1'b0, resp = 1'b0;
    @(posedge clk); #1;
    imem_if.rd_en = 1'b1; imem_if.addr = 64'h700;
    while (rdys < 4 && cycles < 80) begin
      @(negedge clk);
      if (mem_if.rd_en === 1'b1) begin
        if (outst) viol++;
        outst = 1'b1; issues++; resp = 1'b1;
      end
      if (imem_if.rdy === 1'b1) begin
        rdys++; outst = 1'b0;
      end
      if (rdys < 4) begin
        @(posedge clk); #1;
        mem_if.rdy = resp; resp = 1'b0;
        if (mem_if.rdy && rdys == 3) imem_if.rd_en = 1'b0;
        cycles++;
      end
    end
    @(posedge clk); #1 mem_if.rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_if.rd_en === 1'b1) issues++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (cycles >= 80) begin
      n_fail++;
      $display("FAIL b2b_timeout: %0d rdy pulses after %0d cycles required 4", rdys, cycles);
    end
    n_tests++;
    if (issues != 4 || rdys != 4) begin
      n_fail++;
      $display("FAIL b2b_count: issues=%0d rdys=%0d required 4 4", issues, rdys);
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL b2b_overlap: %0d issues while outstanding required 0", viol);
    end
  endtask

  // Model: each requester holds at most one request from acceptance until its
  // completion cycle; the port serves one transaction at a time.
  task automatic test_random();
    bit       pend [2];
    bit       outs [2];
    mem_req_t q    [2];
    bit       flight = 1'b0;
    int       own = 0, last = 1, lat = 0, win, r;
    bit       exp_fire, exp_ir, exp_dr, acc_i, acc_d;
    for (int k = 0; k < 2; k++) begin pend[k] = 1'b0; outs[k] = 1'b0; q[k] = '0; end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      imem_if.rd_en   = 1'($urandom_range(0, 1));
      imem_if.addr    = {$urandom, $urandom};
      r = int'($urandom_range(0, 3));
      dmem_if.rd_en   = (r == 1);
      dmem_if.wr_en   = (r == 2);
      dmem_if.addr    = {$urandom, $urandom};
      dmem_if.wr_size = SIZE_W'($urandom_range(0, 7));
      dmem_if.wr_data = {$urandom, $urandom};
      mem_if.busy     = ($urandom_range(0, 3) == 0);
      mem_if.rdy      = flight && (lat == 0);
      mem_if.rd_data  = {$urandom, $urandom};
      @(negedge clk);
      exp_fire = !flight && (pend[0] || pend[1]) && !mem_if.busy;
      if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_RR_EN
        win = (last == 1) ? 0 : 1;
`else
        win = 1;
`endif
      end else begin
        win = pend[1] ? 1 : 0;
      end
      n_tests++;
      if (imem_if.busy !== outs[0] || dmem_if.busy !== outs[1]) begin
        n_fail++;
        $display("FAIL rnd_busy c%0d: imem=%b dmem=%b required %b %b", c, imem_if.busy, dmem_if.busy, outs[0], outs[1]);
      end
      n_tests++;
      if (mem_if.rd_en !== (exp_fire && !q[win].is_write) || mem_if.wr_en !== (exp_fire && q[win].is_write)) begin
        n_fail++;
        $display("FAIL rnd_issue c%0d: rd=%b wr=%b required %b %b", c, mem_if.rd_en, mem_if.wr_en,
                 exp_fire && !q[win].is_write, exp_fire && q[win].is_write);
      end
      if (exp_fire) begin
        n_tests++;
        if (mem_if.addr !== q[win].addr ||
            (q[win].is_write && (mem_if.wr_size !== q[win].size || mem_if.wr_data !== q[win].data))) begin
          n_fail++;
          $display("FAIL rnd_payload c%0d: addr=%h size=%0d data=%h required %h %0d %h", c, mem_if.addr,
                   mem_if.wr_size, mem_if.wr_data, q[win].addr, q[win].size, q[win].data);
        end
      end
      exp_ir = flight && mem_if.rdy && (own == 0);
      exp_dr = flight && mem_if.rdy && (own == 1);
      n_tests++;
      if (imem_if.rdy !== exp_ir || dmem_if.rdy !== exp_dr) begin
        n_fail++;
        $display("FAIL rnd_rdy c%0d: irdy=%b drdy=%b required %b %b", c, imem_if.rdy, dmem_if.rdy, exp_ir, exp_dr);
      end
      if (exp_ir || exp_dr) begin
        n_tests++;
        if ((exp_ir ? imem_if.rd_data : dmem_if.rd_data) !== mem_if.rd_data) begin
          n_fail++;
          $display("FAIL rnd_rdata c%0d: got %h required %h", c,
                   exp_ir ? imem_if.rd_data : dmem_if.rd_data, mem_if.rd_data);
        end
      end
      acc_i = imem_if.rd_en && !outs[0];
      acc_d = (dmem_if.rd_en || dmem_if.wr_en) && !outs[1];
      if (flight && mem_if.rdy) begin
        flight = 1'b0; outs[own] = 1'b0;
      end else if (flight) begin
        lat--;
      end
      if (exp_fire) begin
        pend[win] = 1'b0; flight = 1'b1; own = win; last = win;
        lat = int'($urandom_range(0, 3));
      end
      if (acc_i) begin
        pend[0] = 1'b1; outs[0] = 1'b1;
        q[0] = '{is_write: 1'b0, addr: imem_if.addr, size: '0, data: '0};
      end
      if (acc_d) begin
        pend[1] = 1'b1; outs[1] = 1'b1;
        q[1] = '{is_write: dmem_if.wr_en, addr: dmem_if.addr, size: dmem_if.wr_size, data: dmem_if.wr_data};
      end
    end
    @(posedge clk); #1 idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_lone_fetch();
    test_priority();
    test_write();
    test_mem_busy();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
